// File: rtl/div.sv
// 32-bit restoring divider for the EX stage (DIV / DIVU).
// Result: [63:32] remainder, [31:0] quotient; fixed 34-edge latency.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        FREE,
        BYZERO,
        ON,
        END
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] rem_q, rem_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        ge;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // One restoring step: 33-bit compare/subtract so divisor 0xFFFFFFFF fits.
    always_comb begin
        shifted = {rem_q, dvd_q[31]};
        diff    = shifted - {1'b0, dvs_q};
        ge      = shifted[32] | ~diff[32];
        quo_fix = negq_q ? (32'd0 - dvd_q) : dvd_q;
        rem_fix = negr_q ? (32'd0 - rem_q) : rem_q;
    end

    // Next-state and datapath updates for the four-state divider FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        ready_d  = ready_q;
        unique case (state_q)
            FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d = ON;
                        cnt_d   = '0;
                        rem_d   = '0;
                        dvd_d   = (signed_div_i && opdata1_i[31])
                                  ? (32'd0 - opdata1_i) : opdata1_i;
                        dvs_d   = (signed_div_i && opdata2_i[31])
                                  ? (32'd0 - opdata2_i) : opdata2_i;
                        negq_d  = signed_div_i
                                  & (opdata1_i[31] ^ opdata2_i[31]);
                        negr_d  = signed_div_i & opdata1_i[31];
                    end
                end
            end
            BYZERO: begin
                if (annul_i) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else begin
                    state_d  = END;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt_q != 6'd32) begin
                    rem_d = ge ? diff[31:0] : shifted[31:0];
                    dvd_d = {dvd_q[30:0], ge};
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    state_d  = END;
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                end
            end
            END: begin
                if (!start_i) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: state_d = FREE;
        endcase
    end

    // State and datapath registers, cleared immediately on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= FREE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: driver pushes model results,
// monitor pops and compares on each ready_o rise.
module tb_div;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    div dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [63:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   checks = 0;
    int   passes = 0;
    logic prev = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s: got %h want %h", nm, act, want);
    endtask

    // Reference: plain signed/unsigned 64-bit arithmetic, zero divisor -> 0.
    function automatic logic [63:0] model(input logic s,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, qq, rr;
        if (b == 32'd0) return 64'd0;
        sa = s ? {{32{a[31]}}, a} : {32'd0, a};
        sb = s ? {{32{b[31]}}, b} : {32'd0, b};
        qq = sa / sb;
        rr = sa % sb;
        return {rr[31:0], qq[31:0]};
    endfunction

    // Monitor: every ready_o rise must match the oldest pending result.
    always @(negedge clk) begin
        if (!rst) begin
            prev = 1'b0;
        end else begin
            if (ready_o && !prev) begin
                if (q.size() == 0) begin
                    chk("spurious_ready", {63'd0, ready_o}, 64'd0);
                end else begin
                    me = q.pop_front();
                    chk("result", result_o, me.res);
                    chk("latency", 64'(cyc - me.acc + 1), 64'(me.lat));
                end
            end
            prev = ready_o;
        end
    end

    task automatic start_op(input logic s, input logic [31:0] a,
                            input logic [31:0] b, input bit push);
        exp_t e;
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        if (push) begin
            e.res = model(s, a, b);
            e.acc = cyc + 1;
            e.lat = (b == 32'd0) ? 2 : 34;
            q.push_back(e);
        end
    endtask

    task automatic wait_ready();
        int   n;
        exp_t d;
        n = 0;
        while (!ready_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            chk("timeout", {63'd0, ready_o}, 64'd1);
            if (q.size() > 0) d = q.pop_front();
        end
    endtask

    task automatic run_op(input logic s, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] want;
        want = model(s, a, b);
        start_op(s, a, b, 1);
        @(negedge clk);
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom);
        wait_ready();
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            annul_i = 1'b1;
        end
        @(negedge clk);
        annul_i = 1'b0;
        chk("hold", result_o, want);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("clear_rdy", {63'd0, ready_o}, 64'd0);
        chk("clear_res", result_o, 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        #1;
        chk("rst_rdy", {63'd0, ready_o}, 64'd0);
        chk("rst_res", result_o, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_op(1'b0, 32'd100, 32'd7);
        run_op(1'b1, 32'hFFFFFFF9, 32'd2);
        run_op(1'b0, 32'hFFFFFFF9, 32'd2);
        run_op(1'b1, 32'h12345678, 32'd0);
        run_op(1'b0, 32'h12345678, 32'd0);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF);
        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op(1'b1, 32'd7, 32'hFFFFFFFE);

        // Annul mid-ON, then an immediate new start.
        start_op(1'b0, 32'd100, 32'd7, 0);
        repeat (9) @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("annul_rdy", {63'd0, ready_o}, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        run_op(1'b0, 32'd9, 32'd3);

        // Annul in BYZERO.
        start_op(1'b1, 32'd5, 32'd0, 0);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        repeat (4) @(negedge clk);

        // Async reset mid-ON.
        start_op(1'b0, 32'd1000, 32'd3, 0);
        repeat (19) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rston_rdy", {63'd0, ready_o}, 64'd0);
        chk("rston_res", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        run_op(1'b0, 32'd50, 32'd5);

        // Async reset while END holds a nonzero result.
        start_op(1'b0, 32'hDEADBEEF, 32'd3, 1);
        @(negedge clk);
        wait_ready();
        #2 rst = 1'b0;
        #1;
        chk("rstend_rdy", {63'd0, ready_o}, 64'd0);
        chk("rstend_res", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h80000000;
                3: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            run_op(1'($urandom), a, b);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001: Parameters: none; widths fixed at 32-bit operands and a 64-bit result.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004: signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled only on accepted start.
REQ-005: opdata1_i  input  32  dividend (rs); sampled only on accepted start.
REQ-006: opdata2_i  input  32  divisor (rt); sampled only on accepted start.
REQ-007: start_i  input  1  1 = request division; the EX stage holds it high until it sees ready_o, then drops it.
REQ-008: annul_i  input  1  1 = abort the operation in progress (pipeline flush).
REQ-009: result_o  output  64  [63:32] = remainder (to HI), [31:0] = quotient (to LO); registered.
REQ-010: ready_o  output  1  1 = result_o valid; registered.

Function
REQ-011: The FSM SHALL have exactly four states: FREE, BYZERO, ON, END.
REQ-012: FREE, start_i=1, annul_i=0, opdata2_i=0: the next edge SHALL go to BYZERO.
REQ-013: FREE, start_i=1, annul_i=0, opdata2_i!=0: the next edge SHALL latch the operands and go to ON with iteration counter cnt=0.
REQ-014: FREE with start_i=0 or annul_i=1 SHALL stay in FREE, with ready_o=0 and result_o=0.
REQ-015: Signed mode SHALL latch absolute values (two's-complement negate when bit31=1); unsigned mode SHALL latch raw values.
REQ-016: In ON, each edge with cnt<32 SHALL perform one restoring-division step: shift {rem, dividend} left by 1; if the shifted partial remainder >= divisor, subtract the divisor and set quotient bit=1, else set quotient bit=0; then cnt+1.
REQ-017: The subtraction SHALL be 33 bits wide so that divisor 0xFFFFFFFF is handled without overflow.
REQ-018: In ON with cnt==32, the next edge SHALL go to END and set ready_o=1.
REQ-019: On that same edge, in signed mode, the quotient SHALL be negated iff the operand signs differ, and the remainder SHALL be negated iff the dividend was negative.
REQ-020: BYZERO SHALL go to END on the next edge with result_o=0 and ready_o=1.
REQ-021: END SHALL hold result_o and ready_o while start_i=1.
REQ-022: END with start_i=0 SHALL return to FREE on the next edge, clearing ready_o and result_o to 0.
REQ-023: Latency SHALL be fixed: counting the start-accepting edge as edge 1, ready_o rises after edge 34 for a nonzero divisor and after edge 2 for a zero divisor.
REQ-024: annul_i=1 in ON or BYZERO SHALL return to FREE on the next edge with ready_o=0 and result_o=0; annul_i SHALL be ignored in END.
REQ-025: Operand changes on inputs after acceptance SHALL NOT affect the result.
REQ-026: Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0, with no exception.
REQ-027: ready_o SHALL never be 1 outside END.

Reset
REQ-028: rst=0 SHALL immediately, without waiting for clk, force state FREE, cnt=0, ready_o=0, result_o=0, and clear all operand and partial-remainder registers.
REQ-029: rst asserted mid-operation (ON or END) SHALL discard the operation.
REQ-030: After rst releases, the first edge SHALL be able to accept a new start.

Verification
REQ-031: Unsigned 100 / 7, start held -> ready_o=1 after edge 34; result_o = {0x00000002, 0x0000000E}; drop start -> ready_o=0 after 1 edge.
REQ-032: Signed -7 (0xFFFFFFF9) / 2 -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}; unsigned 0xFFFFFFF9 / 2 -> {0x00000001, 0x7FFFFFFC}.
REQ-033: Divide by zero (either mode, 0x12345678 / 0) -> ready_o=1 after edge 2; result_o = 0.
REQ-034: Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}; unsigned 0xFFFFFFFF / 0xFFFFFFFF -> {0x00000000, 0x00000001}.
REQ-035: annul_i=1 pulsed at edge 10 of ON -> FREE next edge, ready_o stays 0; an immediate new start 9 / 3 -> {0, 3} with full 34-edge latency.
REQ-036: rst=0 asserted asynchronously at edge 20 of ON -> ready_o and result_o are 0 before the next clk edge; after release, 50 / 5 -> {0, 10}.
